// File: rtl/tpc_pkg.sv
// Shared definitions for the traffic phase controller: car-light encodings and
// the sequencer state enum.
package tpc_pkg;

   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_GREEN  = 2'b10;

   typedef enum logic [2:0] {
      ST_ALL_RED = 3'd0,
      ST_WALK    = 3'd1,
      ST_FLASH   = 3'd2,
      ST_GREEN   = 3'd3,
      ST_YELLOW  = 3'd4,
      ST_HOLD    = 3'd5
   } tpc_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Restartable prescaler: tick is high for one cycle every TICK_DIV cycles,
// counted from the cycle after restart.
module tick_prescaler #(
   parameter int TICK_DIV = 5000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/traffic_phase_controller.sv
// Round-robin intersection sequencer: all-red, optional walk/flash, green and
// yellow per phase, with latched pedestrian requests and an enable-driven hold.
module traffic_phase_controller
   import tpc_pkg::*;
#(
   parameter int NUM_PHASES = 2,
   parameter int TIME_W     = 6,
   parameter int TICK_DIV   = 5000,
   localparam int PW = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [TIME_W-1:0]       green_time,
   input  logic [TIME_W-1:0]       yellow_time,
   input  logic [TIME_W-1:0]       all_red_time,
   input  logic [TIME_W-1:0]       walk_time,
   input  logic [TIME_W-1:0]       flash_time,
   input  logic [NUM_PHASES-1:0]   ped_req,
   output logic [2*NUM_PHASES-1:0] phase_lights,
   output logic [NUM_PHASES-1:0]   walk,
   output logic [NUM_PHASES-1:0]   ped_flash,
   output logic                    blink,
   output logic [PW-1:0]           active_phase,
   output tpc_state_e              fsm_state
);

   // Last tick index of an interval; a zero-length request still lasts one tick.
   function automatic logic [TIME_W-1:0] span(input logic [TIME_W-1:0] d);
      return (d == '0) ? '0 : d - TIME_W'(1);
   endfunction

   tpc_state_e              state, state_next;
   logic [PW-1:0]           phase_next;
   logic [NUM_PHASES-1:0]   pending, pending_next;
   logic [TIME_W-1:0]       elapsed, limit, interval_next;
   logic                    unsampled, first;
   logic                    tick, expire, transition;
   logic [2*NUM_PHASES-1:0] lights_next;
   logic [NUM_PHASES-1:0]   walk_next, flash_next;
   logic                    blink_next;

   assign fsm_state  = state;
   assign transition = (state_next != state);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (transition),
      .tick    (tick)
   );

   always_comb begin
      state_next = state;
      phase_next = active_phase;
      // The all-red interval right after reset has no entry sample, so it reads the input live.
      expire     = tick && (elapsed == (unsampled ? span(all_red_time) : limit));
      if (!enable) begin
         state_next = ST_HOLD;
      end else begin
         case (state)
            ST_HOLD:    state_next = ST_ALL_RED;
            ST_ALL_RED: if (expire) begin
               if (first || active_phase == PW'(NUM_PHASES - 1)) phase_next = '0;
               else                                             phase_next = active_phase + PW'(1);
               state_next = (pending[phase_next] | ped_req[phase_next]) ? ST_WALK : ST_GREEN;
            end
            ST_WALK:    if (expire) state_next = ST_FLASH;
            ST_FLASH:   if (expire) state_next = ST_GREEN;
            ST_GREEN:   if (expire) state_next = ST_YELLOW;
            ST_YELLOW:  if (expire) state_next = ST_ALL_RED;
            default:    state_next = ST_ALL_RED;
         endcase
      end
   end

   always_comb begin
      interval_next = '0;
      case (state_next)
         ST_ALL_RED: interval_next = all_red_time;
         ST_WALK:    interval_next = walk_time;
         ST_FLASH:   interval_next = flash_time;
         ST_GREEN:   interval_next = green_time;
         ST_YELLOW:  interval_next = yellow_time;
         default:    interval_next = '0;
      endcase
   end

   always_comb begin
      pending_next = pending | ped_req;
      if (transition && state_next == ST_WALK) pending_next[phase_next] = 1'b0;
   end

   always_comb begin
      lights_next = {NUM_PHASES{LIGHT_RED}};
      walk_next   = '0;
      flash_next  = '0;
      blink_next  = 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (PW'(i) == phase_next) begin
            case (state_next)
               ST_WALK:   begin lights_next[2*i +: 2] = LIGHT_GREEN; walk_next[i]  = 1'b1; end
               ST_FLASH:  begin lights_next[2*i +: 2] = LIGHT_GREEN; flash_next[i] = 1'b1; end
               ST_GREEN:  lights_next[2*i +: 2] = LIGHT_GREEN;
               ST_YELLOW: lights_next[2*i +: 2] = LIGHT_YELLOW;
               default:   ;
            endcase
         end
      end
      if (state_next == ST_FLASH) blink_next = (state != ST_FLASH) ? 1'b1 : (tick ? ~blink : blink);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_ALL_RED;
         active_phase <= '0;
         pending      <= '0;
         elapsed      <= '0;
         limit        <= '0;
         unsampled    <= 1'b1;
         first        <= 1'b1;
         phase_lights <= '0;
         walk         <= '0;
         ped_flash    <= '0;
         blink        <= 1'b0;
      end else begin
         state        <= state_next;
         active_phase <= phase_next;
         pending      <= pending_next;
         phase_lights <= lights_next;
         walk         <= walk_next;
         ped_flash    <= flash_next;
         blink        <= blink_next;
         if (transition) begin
            elapsed   <= '0;
            limit     <= span(interval_next);
            unsampled <= 1'b0;
         end else if (tick && state != ST_HOLD) begin
            elapsed <= elapsed + TIME_W'(1);
         end
         if (transition && state == ST_ALL_RED && state_next != ST_HOLD) first <= 1'b0;
      end
   end

endmodule
